// File: rtl/kypd_key_entry.sv
// Debounced keypad press capture and 4-digit BCD operand entry.
// Emits single-cycle key/operator events downstream of the keypad decoder.
module kypd_key_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  decode,
  input  logic        key_active,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] entry,
  output logic [2:0]  digit_count,
  output logic        overflow,
  output logic        op_valid,
  output logic [3:0]  op_code,
  output logic [15:0] operand
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_e;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [3:0]        cand_q, cand_d;
  logic              accept;

  logic              key_valid_q, key_valid_d;
  logic [3:0]        key_code_q, key_code_d;
  logic [15:0]       entry_q, entry_d;
  logic [2:0]        digit_count_q, digit_count_d;
  logic              overflow_q, overflow_d;
  logic              op_valid_q, op_valid_d;
  logic [3:0]        op_code_q, op_code_d;
  logic [15:0]       operand_q, operand_d;

  assign cnt_inc = cnt_q + CNT_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cand_q        <= '0;
      key_valid_q   <= 1'b0;
      key_code_q    <= '0;
      entry_q       <= '0;
      digit_count_q <= '0;
      overflow_q    <= 1'b0;
      op_valid_q    <= 1'b0;
      op_code_q     <= '0;
      operand_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cand_q        <= cand_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      entry_q       <= entry_d;
      digit_count_q <= digit_count_d;
      overflow_q    <= overflow_d;
      op_valid_q    <= op_valid_d;
      op_code_q     <= op_code_d;
      operand_q     <= operand_d;
    end
  end

  // Debounce FSM; the counter is cleared on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_active) begin
          cand_d  = decode;
          cnt_d   = CNT_ONE;
          state_d = PRESS_WAIT;
        end
      end
      PRESS_WAIT: begin
        if (!key_active) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (decode != cand_q) begin
          cand_d = decode;
          cnt_d  = CNT_ONE;
        end else if (cnt_inc == DEB_LAST) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = HELD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (!key_active) begin
          cnt_d   = CNT_ONE;
          state_d = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (key_active) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_inc == DEB_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Entry buffer / operator datapath, updated only on an accepted press.
  always_comb begin
    key_valid_d   = 1'b0;
    op_valid_d    = 1'b0;
    key_code_d    = key_code_q;
    entry_d       = entry_q;
    digit_count_d = digit_count_q;
    overflow_d    = overflow_q;
    op_code_d     = op_code_q;
    operand_d     = operand_q;
    if (accept) begin
      key_valid_d = 1'b1;
      key_code_d  = cand_q;
      if (cand_q <= 4'd9) begin
        if (digit_count_q < 3'd4) begin
          entry_d       = {entry_q[11:0], cand_q};
          digit_count_d = digit_count_q + 3'd1;
        end else begin
          overflow_d = 1'b1;
        end
      end else if (cand_q == 4'hC) begin
        entry_d       = '0;
        digit_count_d = '0;
        overflow_d    = 1'b0;
      end else begin
        op_valid_d    = 1'b1;
        op_code_d     = cand_q;
        operand_d     = entry_q;
        entry_d       = '0;
        digit_count_d = '0;
      end
    end
  end

  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign entry       = entry_q;
  assign digit_count = digit_count_q;
  assign overflow    = overflow_q;
  assign op_valid    = op_valid_q;
  assign op_code     = op_code_q;
  assign operand     = operand_q;

endmodule

// File: tb/tb_kypd_key_entry.sv
// Scoreboard bench for kypd_key_entry with DEBOUNCE_CYCLES=4.
module tb_kypd_key_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  decode;
  logic        key_active;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] entry;
  logic [2:0]  digit_count;
  logic        overflow;
  logic        op_valid;
  logic [3:0]  op_code;
  logic [15:0] operand;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] entry;
    logic [2:0]  cnt;
    logic        ovf;
    logic        is_op;
    logic [15:0] operand;
  } exp_t;

  exp_t exp_q[$];

  kypd_key_entry #(.DEBOUNCE_CYCLES(4), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .decode(decode), .key_active(key_active),
    .key_valid(key_valid), .key_code(key_code), .entry(entry),
    .digit_count(digit_count), .overflow(overflow), .op_valid(op_valid),
    .op_code(op_code), .operand(operand)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [3:0] k, input logic [15:0] e, input logic [2:0] c,
                      input logic o, input logic op, input logic [15:0] opnd);
    exp_t x;
    x.code = k; x.entry = e; x.cnt = c; x.ovf = o; x.is_op = op; x.operand = opnd;
    exp_q.push_back(x);
  endtask

  task automatic press(input logic [3:0] k);
    decode = k; key_active = 1'b1;
    tick(6);
    key_active = 1'b0;
    tick(6);
  endtask

  // Counts negedges until key_valid rises, bounded.
  task automatic wait_kv(input int exp_lat, input string nm);
    int n = 0;
    do begin
      tick(1);
      n++;
    end while (!key_valid && n < 20);
    chk(nm, 32'(n), 32'(exp_lat));
  endtask

  // Monitor: every key_valid pulse must match the oldest expected event.
  logic kv_prev = 1'b0;
  always @(negedge clk) begin
    exp_t x;
    if (op_valid && !key_valid) begin
      checks++; errors++;
      $display("FAIL op_valid_alone: op_valid=1 key_valid=0");
    end
    if (key_valid && kv_prev) begin
      checks++; errors++;
      $display("FAIL kv_width: key_valid high two cycles");
    end
    if (key_valid && !kv_prev) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_event: key_code=0x%0h with no expected event", key_code);
      end else begin
        x = exp_q.pop_front();
        chk("ev_key_code", 32'(key_code), 32'(x.code));
        chk("ev_entry", 32'(entry), 32'(x.entry));
        chk("ev_digit_count", 32'(digit_count), 32'(x.cnt));
        chk("ev_overflow", 32'(overflow), 32'(x.ovf));
        chk("ev_op_valid", 32'(op_valid), 32'(x.is_op));
        if (x.is_op) begin
          chk("ev_op_code", 32'(op_code), 32'(x.code));
          chk("ev_operand", 32'(operand), 32'(x.operand));
        end
      end
    end
    kv_prev = key_valid;
  end

  initial begin
    rst = 1'b1; decode = 4'h0; key_active = 1'b0;
    tick(3);
    chk("rst_entry", 32'(entry), 32'h0);
    chk("rst_key_valid", 32'(key_valid), 32'h0);
    rst = 1'b0;
    tick(2);

    // Digit entry, overflow and clear
    push(4'h1, 16'h0001, 3'd1, 1'b0, 1'b0, 16'h0); press(4'h1);
    push(4'h2, 16'h0012, 3'd2, 1'b0, 1'b0, 16'h0); press(4'h2);
    push(4'h3, 16'h0123, 3'd3, 1'b0, 1'b0, 16'h0); press(4'h3);
    push(4'h4, 16'h1234, 3'd4, 1'b0, 1'b0, 16'h0); press(4'h4);
    push(4'h5, 16'h1234, 3'd4, 1'b1, 1'b0, 16'h0); press(4'h5);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    push(4'hC, 16'h0000, 3'd0, 1'b0, 1'b0, 16'h0); press(4'hC);

    // Operator captures pre-clear entry
    push(4'h4, 16'h0004, 3'd1, 1'b0, 1'b0, 16'h0); press(4'h4);
    push(4'h2, 16'h0042, 3'd2, 1'b0, 1'b0, 16'h0); press(4'h2);
    push(4'hA, 16'h0000, 3'd0, 1'b0, 1'b1, 16'h0042); press(4'hA);
    chk("operand_held", 32'(operand), 32'h0042);
    chk("op_code_held", 32'(op_code), 32'hA);
    chk("op_valid_low", 32'(op_valid), 32'h0);

    // Reset mid-press clears everything; held key re-debounces once
    push(4'h7, 16'h0007, 3'd1, 1'b0, 1'b0, 16'h0); press(4'h7);
    decode = 4'h5; key_active = 1'b1;
    tick(2);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {key_code, entry, digit_count, overflow, op_valid, key_valid, 4'h0},
        32'h0);
    chk("midrst_operand", {op_code, operand}, 32'h0);
    tick(2);
    push(4'h5, 16'h0005, 3'd1, 1'b0, 1'b0, 16'h0);
    rst = 1'b0;
    wait_kv(4, "post_rst_latency");
    tick(4);
    key_active = 1'b0;
    tick(6);

    // Short active glitches give no event
    for (int i = 0; i < 2; i++) begin
      decode = 4'h3; key_active = 1'b1; tick(3);
      key_active = 1'b0; tick(5);
    end

    // Release glitch mid-hold gives a single event
    push(4'h6, 16'h0056, 3'd2, 1'b0, 1'b0, 16'h0);
    decode = 4'h6; key_active = 1'b1; tick(6);
    key_active = 1'b0; tick(2);
    key_active = 1'b1; tick(6);
    key_active = 1'b0; tick(6);

    // Code change during press restarts the count
    push(4'h8, 16'h0568, 3'd3, 1'b0, 1'b0, 16'h0);
    decode = 4'h7; key_active = 1'b1; tick(2);
    decode = 4'h8;
    wait_kv(4, "restart_latency");
    chk("restart_code", 32'(key_code), 32'h8);
    tick(3);
    key_active = 1'b0; tick(6);

    // Long hold with code change: one event, one digit
    push(4'h9, 16'h5689, 3'd4, 1'b0, 1'b0, 16'h0);
    decode = 4'h9; key_active = 1'b1; tick(25);
    decode = 4'h2; tick(25);
    key_active = 1'b0; tick(8);
    chk("hold_entry", 32'(entry), 32'h5689);
    chk("hold_digit_count", 32'(digit_count), 32'h4);

    tick(5);
    chk("pending_events", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kypd_key_entry.md
# kypd_key_entry

Debounced key-press capture and operand-entry stage that sits directly downstream of the keypad `Decoder`. It consumes the decoder's 4-bit key code plus a key-active flag. It produces single-cycle key events, a 4-digit BCD entry buffer for the seven-segment display path, and operator events with the completed operand for the calculator core.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive identical samples required to accept a press or a release (10 ms at 100 MHz); legal range 2..2^24-1.
- `CNT_W`, default 24: debounce counter width; must hold `DEBOUNCE_CYCLES`.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  100 MHz system clock.
  - `rst`  in  1  asynchronous reset, active-high.
- `decode`  in  4  key code from `Decoder` (0x0–0xF).
- `key_active`  in  1  1 while any keypad row reads pressed during the scan.
- `key_valid`  out  1  one-cycle pulse when a press is accepted.
- `key_code`  out  4  code of the last accepted key; held until the next accepted press.
- `entry`  out  16  4-digit BCD entry buffer; `[15:12]` is the oldest digit.
- `digit_count`  out  3  number of digits in `entry`, 0..4.
- `overflow`  out  1  sticky; set when a digit is pressed while `digit_count`=4.
- `op_valid`  out  1  one-cycle pulse when an operator key is accepted.
- `op_code`  out  4  code of the last accepted operator key (0xA, 0xB, 0xD, 0xE or 0xF).
- `operand`  out  16  value of `entry` immediately before the operator press cleared it; valid with `op_valid`, held afterwards.

## Operation
- All outputs reset to 0. The state machine resets to IDLE, the counter to 0 and the candidate code to 0.
- State machine states are IDLE, PRESS_WAIT, HELD and RELEASE_WAIT. Inputs are sampled on every rising `clk` edge.
  - IDLE:
    - `key_active`=1: candidate ← `decode`, count ← 1, go to PRESS_WAIT.
  - PRESS_WAIT:
    - `key_active`=0: go to IDLE, count ← 0.
    - `decode` ≠ candidate: candidate ← `decode`, count ← 1 (restart).
    - Otherwise count ← count+1. When this sample is the `DEBOUNCE_CYCLES`-th consecutive qualifying sample, accept the press and go to HELD.
  - HELD:
    - `key_active`=0: count ← 1, go to RELEASE_WAIT.
    - Code changes while held are ignored; there is no auto-repeat.
  - RELEASE_WAIT:
    - `key_active`=1: go to HELD, count ← 0 (bounce; no new event).
    - Otherwise count ← count+1. At `DEBOUNCE_CYCLES` consecutive inactive samples, go to IDLE.
- An accepted press with code k does the following, all registered at the acceptance edge:
  - Always: `key_valid` ← 1, `key_code` ← k.
  - k = 0x0–0x9:
    - If `digit_count`<4: `entry` ← {`entry`[11:0], k} and `digit_count` ← `digit_count`+1.
    - Else `entry` and `digit_count` are unchanged and `overflow` ← 1.
  - k = 0xC (clear): `entry` ← 0, `digit_count` ← 0, `overflow` ← 0.
  - k ∈ {0xA, 0xB, 0xD, 0xE, 0xF}: `op_valid` ← 1, `op_code` ← k, `operand` ← `entry` (pre-clear value), then `entry` ← 0 and `digit_count` ← 0. `overflow` is unchanged.
- `key_valid` and `op_valid` are deasserted on the following edge.
- Reset mid-operation, in any state or mid-count, returns everything to reset values immediately. A key held through reset deassertion must debounce again from IDLE and produces one event.

## Timing
- Press latency: `key_active` is first sampled high at edge 1 with a stable code. `key_valid` is high for the cycle following edge `DEBOUNCE_CYCLES`.
- `entry`, `digit_count`, `overflow`, `op_code` and `operand` update on the same edge that `key_valid` rises.
- Minimum spacing between two `key_valid` pulses is 2·`DEBOUNCE_CYCLES` cycles (press, then release, debounce).
- The counter never wraps. It is compared against `DEBOUNCE_CYCLES` and reset on every state change.
- A `key_active` glitch shorter than `DEBOUNCE_CYCLES` in IDLE or PRESS_WAIT produces no event.
- A release glitch shorter than `DEBOUNCE_CYCLES` in HELD or RELEASE_WAIT produces no second event.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.

1. Reset check: assert `rst` mid-PRESS_WAIT with `decode`=5 held active. Expected: all outputs are 0 immediately. After release of `rst`, exactly one `key_valid` pulse occurs, 4 cycles later, with `key_code`=5.
2. Debounce and bounce check:
   - Drive `key_active` pulses 3 cycles wide. Expected: no event.
   - Drive a press with a 2-cycle release glitch mid-hold. Expected: exactly one `key_valid`.
   - Change `decode` 7→8 at sample 3. Expected: the count restarts, and `key_code`=8 appears 4 samples after the change.
3. Digit entry: press 1, 2, 3, 4 and then 5, with a clean release between presses. Expected: `entry`=0x1234, `digit_count`=4 and `overflow`=1 after the 5th press. Then press C. Expected: `entry`=0, `digit_count`=0, `overflow`=0.
4. Operator: enter 0x0042, then press A. Expected:
   - `op_valid` is a single-cycle pulse coincident with `key_valid`.
   - `op_code`=0xA, `operand`=0x0042, `entry`=0, `digit_count`=0.
   - `operand` stays 0x0042 afterwards.
5. Held key: hold 9 for 50 cycles. Expected: exactly one `key_valid`, and `entry` gains one digit. Changing `decode` while held produces no event.
